real_time_counter: RTL and testbench
====================================

REAL_TIME_COUNTER -- requirements
Module: real_time_counter

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz; sets the seconds prescaler modulus.
REQ-002 clk  input  1  system clock; all state is updated on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 set_mode  input  1  high selects time-setting mode and freezes timekeeping.
REQ-005 inc_min  input  1  single-cycle pulse that increments minutes; already debounced and synchronised to clk.
REQ-006 inc_hour  input  1  single-cycle pulse that increments hours; already debounced and synchronised to clk.
REQ-007 alarm_on  input  1  alarm arm enable.
REQ-008 alarm_hours  input  5  alarm hour, range 0-23.
REQ-009 alarm_minutes  input  6  alarm minute, range 0-59.
REQ-010 hours  output  5  current hour, binary 0-23; feeds the 2-digit BCD converter.
REQ-011 minutes  output  6  current minute, binary 0-59.
REQ-012 seconds  output  6  current second, binary 0-59.
REQ-013 sec_tick  output  1  one-cycle pulse on each seconds advance.
REQ-014 day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-015 alarm_match  output  1  one-cycle alarm pulse.

Function
REQ-016 Prescaler counts 0..CLK_HZ-1 in run mode (set_mode low); the terminal count returns it to 0 and produces the internal tick in the same cycle.
REQ-017 On each internal tick, seconds increments by one and sec_tick is high for exactly the following clk cycle (registered, 1-cycle latency).
REQ-018 seconds 59 -> 0 carries +1 into minutes in the same edge; minutes 59 -> 0 carries +1 into hours in the same edge; hours 23 -> 0.
REQ-019 The tick that moves 23:59:59 to 00:00:00 also asserts day_wrap for exactly one cycle, coincident with sec_tick.
REQ-020 While set_mode is high: prescaler held at 0, seconds held at 0, no ticks, sec_tick, day_wrap and alarm_match held low.
REQ-021 The cycle set_mode rises, seconds clears to 0 and any pending prescaler count is discarded.
REQ-022 In set mode, inc_min increments minutes, wrapping 59 -> 0 with no carry into hours.
REQ-023 In set mode, inc_hour increments hours, wrapping 23 -> 0.
REQ-024 inc_min and inc_hour together in one cycle: both applied independently in that cycle.
REQ-025 inc_min and inc_hour are ignored while set_mode is low.
REQ-026 On set_mode falling, the prescaler starts from 0, so the first tick occurs CLK_HZ cycles later.
REQ-027 hours never exceeds 23, and minutes and seconds never exceed 59, under any input sequence.
REQ-028 All outputs are registered; no combinational path exists from any input to any output.

Reset
REQ-029 rst high asynchronously forces hours=0, minutes=0, seconds=0, prescaler=0, sec_tick=0, day_wrap=0, alarm_match=0.
REQ-030 Release of rst is sampled synchronously; the first tick occurs CLK_HZ cycles after the first rising edge with rst low.
REQ-031 rst asserted mid-carry or mid-set overrides every other input.

Configuration
REQ-032 Macro RTC_ALARM_EN selects the alarm feature.
REQ-033 RTC_ALARM_EN defined: alarm_match pulses one cycle, coincident with sec_tick, when a tick produces seconds==0 with hours==alarm_hours, minutes==alarm_minutes and alarm_on high.
REQ-034 RTC_ALARM_EN undefined: all alarm ports remain present, alarm inputs are ignored, and alarm_match is constant 0; no alarm logic is synthesised.

Verification
REQ-035 CLK_HZ=4, rst pulse then run -> sec_tick every 4 cycles; seconds 0,1,2,...,59,0; minutes increments on the 60th tick.
REQ-036 Run from reset with CLK_HZ=4 until 23:59:59, next tick -> 00:00:00 with day_wrap and sec_tick high for the same single cycle.
REQ-037 set_mode=1 at seconds=37, inc_min x61, inc_hour x25 -> seconds=0, minutes=(start+61) mod 60, hours=(start+25) mod 24, no sec_tick.
REQ-038 In set mode, assert inc_min and inc_hour together at minutes=59, hours=23 -> both become 0 in the same cycle; hours does not gain an extra carry.
REQ-039 RTC_ALARM_EN defined, alarm 07:30 armed, run through 07:29:59 -> alarm_match one cycle at 07:30:00. Repeat with alarm_on=0, or with the macro undefined -> alarm_match stays 0.
REQ-040 Assert rst asynchronously between clk edges at 12:34:56 -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/real_time_counter.sv
// real_time_counter
//   24-hour wall clock driven by a CLK_HZ prescaler. In run mode the prescaler
//   ticks once per second, and each tick advances seconds. Carries ripple into
//   minutes and hours on the same edge. In set mode timekeeping is frozen and
//   seconds is held at 0. While in set mode, inc_min and inc_hour step the
//   minute and hour fields independently, without carries between them.
//
//   Optional feature: define RTC_ALARM_EN to build the alarm comparator.
//   Without it, the alarm inputs are ignored and alarm_match is always 0.
//
// Parameters
//   CLK_HZ         input clock frequency in Hz (prescaler modulus)
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   set_mode       1 = time-setting mode (timekeeping frozen)
//   inc_min        one-cycle pulse, +1 minute in set mode
//   inc_hour       one-cycle pulse, +1 hour in set mode
//   alarm_on       alarm arm enable
//   alarm_hours    alarm hour, 0-23
//   alarm_minutes  alarm minute, 0-59
//   hours          current hour, 0-23
//   minutes        current minute, 0-59
//   seconds        current second, 0-59
//   sec_tick       one-cycle pulse on each seconds advance
//   day_wrap       one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//   alarm_match    one-cycle pulse when the alarm time is reached
module real_time_counter #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       alarm_on,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm_match
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic          sec_wrap, min_wrap, hr_wrap;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hr_nxt;
  logic          alarm_hit;

  // Each field's +1-with-wrap value. These are shared by the run-mode carry
  // chain and by the set-mode increment buttons.
  always_comb begin
    tick     = !set_mode && (prescaler == TERM);
    sec_wrap = (seconds == 6'd59);
    min_wrap = (minutes == 6'd59);
    hr_wrap  = (hours == 5'd23);
    sec_nxt  = sec_wrap ? 6'd0 : seconds + 6'd1;
    min_nxt  = min_wrap ? 6'd0 : minutes + 6'd1;
    hr_nxt   = hr_wrap  ? 5'd0 : hours + 5'd1;
  end

`ifdef RTC_ALARM_EN
  logic [5:0] alarm_min_cmp;
  logic [4:0] alarm_hr_cmp;

  // The alarm fires on the tick that lands on hh:mm:00. It compares against
  // the time this tick produces, not the time that is currently displayed.
  always_comb begin
    alarm_min_cmp = min_nxt;
    alarm_hr_cmp  = min_wrap ? hr_nxt : hours;
    alarm_hit     = tick && sec_wrap && alarm_on &&
                    (alarm_hr_cmp == alarm_hours) &&
                    (alarm_min_cmp == alarm_minutes);
  end
`else
  logic alarm_unused;
  assign alarm_unused = ^{alarm_on, alarm_hours, alarm_minutes};
  assign alarm_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      hours       <= '0;
      minutes     <= '0;
      seconds     <= '0;
      sec_tick    <= 1'b0;
      day_wrap    <= 1'b0;
      alarm_match <= 1'b0;
    end else if (set_mode) begin
      // Any partial second is discarded, so leaving set mode starts a full
      // CLK_HZ period before the first tick.
      prescaler   <= '0;
      seconds     <= '0;
      sec_tick    <= 1'b0;
      day_wrap    <= 1'b0;
      alarm_match <= 1'b0;
      if (inc_min)  minutes <= min_nxt;
      if (inc_hour) hours   <= hr_nxt;
    end else begin
      sec_tick    <= tick;
      day_wrap    <= tick && sec_wrap && min_wrap && hr_wrap;
      alarm_match <= alarm_hit;
      if (tick) begin
        prescaler <= '0;
        seconds   <= sec_nxt;
        if (sec_wrap)             minutes <= min_nxt;
        if (sec_wrap && min_wrap) hours   <= hr_nxt;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_real_time_counter.sv
module tb_real_time_counter;

  localparam int CLK_HZ = 4;
  localparam int W      = 20;

`ifdef RTC_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       set_mode, inc_min, inc_hour, alarm_on;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       sec_tick, day_wrap, alarm_match;

  real_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .inc_min(inc_min),
    .inc_hour(inc_hour), .alarm_on(alarm_on), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .hours(hours), .minutes(minutes),
    .seconds(seconds), .sec_tick(sec_tick), .day_wrap(day_wrap),
    .alarm_match(alarm_match)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model + scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int m_total;  // seconds since midnight
  int m_cnt;    // run-mode edges since the last tick / set / reset

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int total, input bit t, input bit w, input bit a);
    return {5'(total / 3600), 6'((total / 60) % 60), 6'(total % 60), t, w, a};
  endfunction

  task automatic model_step(input bit sm, input bit im, input bit ih);
    int h, mi;
    bit t, w, a;
    t = 0; w = 0; a = 0;
    if (sm) begin
      m_cnt = 0;
      h  = m_total / 3600;
      mi = (m_total / 60) % 60;
      if (im) mi = (mi + 1) % 60;
      if (ih) h  = (h + 1) % 24;
      m_total = h * 3600 + mi * 60;
    end else begin
      m_cnt++;
      if (m_cnt == CLK_HZ) begin
        m_cnt   = 0;
        m_total = (m_total + 1) % 86400;
        t = 1;
        w = (m_total == 0);
        a = ALARM_EN && alarm_on &&
            (m_total == int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60);
      end
    end
    exp_q.push_back(pack(m_total, t, w, a));
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {hours, minutes, seconds, sec_tick, day_wrap, alarm_match};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit sm, input bit im, input bit ih);
    logic [W-1:0] got, exp;
    set_mode = sm; inc_min = im; inc_hour = ih;
    @(posedge clk);
    model_step(sm, im, ih);
    @(negedge clk);
    got = dut_vec();
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL scoreboard: got %0d:%0d:%0d t%0d w%0d a%0d expected %0d:%0d:%0d t%0d w%0d a%0d",
               got[19:15], got[14:9], got[8:3], got[2], got[1], got[0],
               exp[19:15], exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
    end
    inc_min = 0; inc_hour = 0;
  endtask

  task automatic do_reset();
    rst = 1; set_mode = 0; inc_min = 0; inc_hour = 0;
    @(negedge clk); @(negedge clk);
    check("reset_state", 32'(dut_vec()), 32'd0);
    m_total = 0; m_cnt = 0; exp_q.delete();
    rst = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle(0, 0, 0);
  endtask

  // set-mode helper: nh hour pulses and nm minute pulses, applied together
  task automatic set_time(input int nh, input int nm);
    int n;
    n = (nh > nm) ? nh : nm;
    for (int i = 0; i < n; i++) cycle(1, i < nm, i < nh);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit sm, im, ih;
    int eh, em, es;
    bit et;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int ticks, k, amatch;
    bit sm_r;

    rst = 1; set_mode = 0; inc_min = 0; inc_hour = 0;
    alarm_on = 0; alarm_hours = 0; alarm_minutes = 0;

    tbl[0] = '{1, 1, 0, 0, 1, 0, 0};  // minute +1
    tbl[1] = '{1, 0, 1, 1, 1, 0, 0};  // hour +1
    tbl[2] = '{1, 1, 1, 2, 2, 0, 0};  // both together
    tbl[3] = '{0, 1, 1, 2, 2, 0, 0};  // buttons ignored in run, prescaler 1
    tbl[4] = '{0, 0, 0, 2, 2, 0, 0};
    tbl[5] = '{0, 0, 0, 2, 2, 0, 0};
    tbl[6] = '{0, 0, 0, 2, 2, 1, 1};  // CLK_HZ-th run edge ticks
    tbl[7] = '{0, 0, 0, 2, 2, 1, 0};
    tbl[8] = '{1, 0, 0, 2, 2, 0, 0};  // entering set clears seconds

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].sm, tbl[i].im, tbl[i].ih);
      check($sformatf("tbl[%0d]", i), 32'({hours, minutes, seconds, sec_tick}),
            32'({5'(tbl[i].eh), 6'(tbl[i].em), 6'(tbl[i].es), tbl[i].et}));
    end

    // one minute of ticks from reset
    do_reset();
    ticks = 0;
    for (int i = 0; i < 60 * CLK_HZ; i++) begin
      cycle(0, 0, 0);
      if (sec_tick) begin
        ticks++;
        if (ticks <= 3 || ticks == 59) check("tick_seconds", 32'(seconds), 32'(ticks % 60));
      end
    end
    check("minute_ticks", 32'(ticks), 32'd60);
    check("minute_carry", 32'({minutes, seconds}), 32'({6'd1, 6'd0}));

    // set mode at seconds 37, 61 minute and 25 hour pulses
    do_reset();
    run(37 * CLK_HZ);
    check("sec_37", 32'(seconds), 32'd37);
    ticks = 0;
    cycle(1, 0, 0);
    for (int i = 0; i < 61; i++) begin
      cycle(1, 1, 0); ticks += sec_tick; cycle(1, 0, 0); ticks += sec_tick;
    end
    for (int i = 0; i < 25; i++) begin
      cycle(1, 0, 1); ticks += sec_tick; cycle(1, 0, 0); ticks += sec_tick;
    end
    check("set_time", 32'({hours, minutes, seconds}), 32'({5'd1, 6'd1, 6'd0}));
    check("set_no_tick", 32'(ticks), 32'd0);

    // 23:59 then both buttons together -> 00:00 without extra hour carry
    set_time(22, 58);
    check("set_23_59", 32'({hours, minutes}), 32'({5'd23, 6'd59}));
    cycle(1, 1, 1);
    check("both_wrap", 32'({hours, minutes}), 32'd0);

    // day rollover
    set_time(23, 59);
    run(59 * CLK_HZ);
    check("at_235959", 32'({hours, minutes, seconds}), 32'({5'd23, 6'd59, 6'd59}));
    run(CLK_HZ);
    check("day_wrap", 32'({hours, minutes, seconds, sec_tick, day_wrap}),
          32'({5'd0, 6'd0, 6'd0, 1'b1, 1'b1}));
    cycle(0, 0, 0);
    check("day_wrap_pulse", 32'({sec_tick, day_wrap}), 32'd0);

    // alarm at 07:30 armed
    do_reset();
    alarm_on = 1; alarm_hours = 7; alarm_minutes = 30;
    set_time(7, 29);
    run(60 * CLK_HZ - 1);
    check("pre_alarm", 32'({hours, minutes, seconds, alarm_match}),
          32'({5'd7, 6'd29, 6'd59, 1'b0}));
    cycle(0, 0, 0);
    check("alarm_hit", 32'({hours, minutes, seconds, alarm_match}),
          32'({5'd7, 6'd30, 6'd0, ALARM_EN}));
    cycle(0, 0, 0);
    check("alarm_pulse", 32'(alarm_match), 32'd0);

    // same time with alarm disarmed
    alarm_on = 0;
    set_time(0, 59);
    amatch = 0;
    for (int i = 0; i < 62 * CLK_HZ; i++) begin
      cycle(0, 0, 0); amatch += alarm_match;
    end
    check("alarm_off", 32'(amatch), 32'd0);

    // asynchronous reset between edges at 12:34:56
    do_reset();
    set_time(12, 34);
    run(56 * CLK_HZ);
    check("at_123456", 32'({hours, minutes, seconds}), 32'({5'd12, 6'd34, 6'd56}));
    #2 rst = 1;
    #1 check("async_reset", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst = 0; m_total = 0; m_cnt = 0; exp_q.delete();

    // randomized mode/button traffic against the model
    alarm_hours = 5'($urandom_range(0, 1));
    alarm_minutes = 6'($urandom_range(0, 10));
    sm_r = 0;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 99);
      if (sm_r ? (k < 6) : (k < 1)) sm_r = !sm_r;
      if ($urandom_range(0, 199) == 0) alarm_on = !alarm_on;
      cycle(sm_r, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      if (hours > 23 || minutes > 59 || seconds > 59)
        check("range", 32'({hours, minutes, seconds}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
